// File: rtl/ball_ctrl.sv
// Pong ball controller: per-frame motion, wall/paddle bounce, miss detection and sprite pixel masking.
// Optional BALL_SPEEDUP_EN: every fourth paddle hit raises the horizontal speed by 1, up to VEL_MAX.
module ball_ctrl #(
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int VEL         = 2,
  parameter int VEL_MAX     = 6,
  parameter int L_PAD_X     = 32,
  parameter int R_PAD_X     = 600,
  parameter int PAD_W       = 4,
  parameter int PAD_H       = 72,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refresh_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [9:0] l_pad_y,
  input  logic [9:0] r_pad_y,
  input  logic       serve,
  input  logic       serve_dir,
  output logic [2:0] rom_row_addr,
  input  logic [7:0] rom_row_data,
  output logic       ball_on,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit,
  output logic       miss_l,
  output logic       miss_r,
  output logic       busy
);

  localparam int VW = $clog2(VEL_MAX + 1);
  localparam int CW = $clog2(MISS_FRAMES + 1);
  localparam logic [9:0] X_CTR = 10'((H_MAX - 8) / 2);
  localparam logic [9:0] Y_CTR = 10'((V_MAX - 8) / 2);
  localparam logic signed [10:0] H_S   = 11'(H_MAX);
  localparam logic signed [10:0] V_S   = 11'(V_MAX);
  localparam logic signed [10:0] LPX_S = 11'(L_PAD_X);
  localparam logic signed [10:0] RPX_S = 11'(R_PAD_X);
  localparam logic signed [10:0] PW_S  = 11'(PAD_W);
  localparam logic signed [10:0] PH_S  = 11'(PAD_H);
  localparam logic signed [10:0] SZ_S  = 11'sd8;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_MISS} state_e;

  state_e        state_q, state_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d, miss_l_q, miss_l_d, miss_r_q, miss_r_d;
  logic          ball_on_q, ball_on_d;
  logic [VW-1:0] vx, vy;
  logic          serve_go;

  logic signed [10:0] sx, sy, sl, sr, svx, svy;
  logic               l_ovl, r_ovl, in_box;
  logic [2:0]         col;

  assign vy       = VW'(VEL);
  assign serve_go = (state_q == S_IDLE) && serve;

  // Rendering path: row/column offsets wrap mod 8, in_box qualifies them.
  assign rom_row_addr = pixel_y[2:0] - by_q[2:0];
  assign col          = pixel_x[2:0] - bx_q[2:0];
  assign in_box = ({1'b0, pixel_x} >= {1'b0, bx_q}) && ({1'b0, pixel_x} < {1'b0, bx_q} + 11'd8) &&
                  ({1'b0, pixel_y} >= {1'b0, by_q}) && ({1'b0, pixel_y} < {1'b0, by_q} + 11'd8);
  assign ball_on_d = in_box && rom_row_data[3'd7 - col];

  assign sx    = {1'b0, bx_q};
  assign sy    = {1'b0, by_q};
  assign sl    = {1'b0, l_pad_y};
  assign sr    = {1'b0, r_pad_y};
  assign svx   = 11'(vx);
  assign svy   = 11'(vy);
  assign l_ovl = (sy + SZ_S > sl) && (sy < sl + PH_S);
  assign r_ovl = (sy + SZ_S > sr) && (sy < sr + PH_S);

`ifdef BALL_SPEEDUP_EN
  logic [1:0]    hc_q;
  logic [VW-1:0] vx_q;
  always_ff @(posedge clk) begin
    if (!reset_n || serve_go) begin
      hc_q <= '0;
      vx_q <= VW'(VEL);
    end else if (hit_d) begin
      hc_q <= hc_q + 2'd1;
      if (hc_q == 2'd3 && vx_q < VW'(VEL_MAX)) vx_q <= vx_q + VW'(1);
    end
  end
  assign vx = vx_q;
`else
  assign vx = VW'(VEL);
`endif

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (serve) begin
          dx_d    = serve_dir;
          dy_d    = 1'b1;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (refresh_tick) begin
          if (!dx_q && sx < svx) begin
            bx_d = '0;  miss_l_d = 1'b1;  state_d = S_MISS;
          end else if (dx_q && sx + SZ_S + svx > H_S) begin
            bx_d = 10'(H_MAX - 8);  miss_r_d = 1'b1;  state_d = S_MISS;
          end else if (!dx_q && sx >= LPX_S && sx <= LPX_S + PW_S && l_ovl) begin
            dx_d = 1'b1;  bx_d = 10'(L_PAD_X + PAD_W);  hit_d = 1'b1;
          end else if (dx_q && sx + SZ_S >= RPX_S && sx + SZ_S <= RPX_S + PW_S && r_ovl) begin
            dx_d = 1'b0;  bx_d = 10'(R_PAD_X - 8);  hit_d = 1'b1;
          end else if (dx_q) begin
            bx_d = bx_q + 10'(vx);
          end else begin
            bx_d = bx_q - 10'(vx);
          end
          // Vertical axis is resolved independently so corner hits flip both directions.
          if (!dy_q && sy < svy) begin
            by_d = '0;  dy_d = 1'b1;
          end else if (dy_q && sy + SZ_S + svy > V_S) begin
            by_d = 10'(V_MAX - 8);  dy_d = 1'b0;
          end else if (dy_q) begin
            by_d = by_q + 10'(vy);
          end else begin
            by_d = by_q - 10'(vy);
          end
        end
      end
      S_MISS: begin
        if (refresh_tick) begin
          if (cnt_q == CW'(MISS_FRAMES - 1)) begin
            cnt_d = '0;  bx_d = X_CTR;  by_d = Y_CTR;  state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bx_q      <= X_CTR;
      by_q      <= Y_CTR;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      miss_l_q  <= 1'b0;
      miss_r_q  <= 1'b0;
      ball_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      miss_l_q  <= miss_l_d;
      miss_r_q  <= miss_r_d;
      ball_on_q <= ball_on_d;
    end
  end

  assign ball_x  = bx_q;
  assign ball_y  = by_q;
  assign hit     = hit_q;
  assign miss_l  = miss_l_q;
  assign miss_r  = miss_r_q;
  assign ball_on = ball_on_q;
  assign busy    = (state_q != S_IDLE);

endmodule
